// File: rtl/uart_tx_if.sv
// Write-side handshake between a byte producer and the UART transmitter.
// The producer drives tx_start/tx_data; the transmitter reports ready, busy and done.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 busy;
    logic                 tx_done;

    modport master (
        output tx_start, tx_data,
        input  tx_ready, busy, tx_done
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_ready, busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, parity, stop bit,
// paced by an external baud enable, with a one-entry holding buffer for back-to-back frames.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tx,
    uart_tx_if.slave   bus,
    output logic       tx
);
    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] buf_data;
    logic [DATA_BITS-1:0] shifter;
    logic [CNT_W-1:0]     count;
    logic                 buf_valid;
    logic                 parity;
    logic                 tx_ready_q;
    logic                 tx_done_q;
    logic                 accept;
    logic                 load;

    // A load can only happen while buf_valid is set, i.e. while tx_ready is low,
    // so accept and load are mutually exclusive on any edge.
    assign accept = bus.tx_start && tx_ready_q;
    assign load   = baud_tx && buf_valid && (state == IDLE || state == STOP);

    assign bus.tx_ready = tx_ready_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.busy     = (state != IDLE) || buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            // NOTE: buffer and shifter are cleared too, so a restart after an aborted frame never replays stale data.
            buf_data   <= '0;
            shifter    <= '0;
            count      <= '0;
            buf_valid  <= 1'b0;
            parity     <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees pre-edge values.
            tx_done_q <= 1'b0;

            if (accept) begin
                buf_data   <= bus.tx_data;
                buf_valid  <= 1'b1;
                tx_ready_q <= 1'b0;
            end else if (load) begin
                buf_valid  <= 1'b0;
                tx_ready_q <= 1'b1;
            end

            if (load) begin
                shifter <= buf_data;
                parity  <= (^buf_data) ^ PARITY_ODD;
            end

            if (baud_tx) begin
                case (state)
                    IDLE: begin
                        if (buf_valid) begin
                            state <= START;
                            tx    <= 1'b0;
                        end
                    end
                    START: begin
                        state <= DATA;
                        tx    <= shifter[0];
                        count <= '0;
                    end
                    DATA: begin
                        if (count == CNT_W'(DATA_BITS - 1)) begin
                            state <= PARITY;
                            tx    <= parity;
                        end else begin
                            tx    <= shifter[count + 1'b1];
                            count <= count + 1'b1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    STOP: begin
                        tx_done_q <= 1'b1;
                        // A pending byte starts immediately: no idle bit between frames.
                        if (buf_valid) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter; the counterpart of the UART receiver on the same link.
- Accepts a byte over a ready/start handshake and shifts out one frame per byte.
- Frame order: start bit (0), DATA_BITS data bits LSB first, one parity bit, one stop bit (1).
- Bit timing comes from an external one-clk-wide baud enable pulse (baud_tx) from the shared baud generator.
- A one-entry holding buffer allows back-to-back frames with no idle gap.

Parameters:
- DATA_BITS, 8: data bits per frame (valid range 5-8).
- PARITY_ODD, 0: parity sense. 0 = even (the receiver's convention: parity bit = XOR of data). 1 = odd (parity bit inverted).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_tx  input  1  baud enable, one clk wide, one per bit period.
- tx_start  input  1  write strobe; qualified by tx_ready.
- tx_data  input  DATA_BITS  byte to send; sampled when tx_start && tx_ready.
- tx  output  1  serial line, registered, idles high.
- tx_ready  output  1  holding buffer empty; a write is accepted.
- busy  output  1  frame in progress or byte pending.
- tx_done  output  1  one-clk pulse at the end of each stop bit.

Behaviour:
- Reset (async, rst=1):
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - State IDLE; buffer invalid; bit counter 0; shift register 0.
  - Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- Write handshake:
  - On a clk edge with tx_start=1 and tx_ready=1, tx_data is captured into the holding buffer; buf_valid=1, so tx_ready=0 from the next cycle.
  - tx_start while tx_ready=0 is ignored; the buffer is not overwritten.
  - tx_ready = !buf_valid, registered.
- Buffer-to-shifter load:
  - Happens only on a baud_tx cycle where the FSM leaves IDLE or leaves STOP with buf_valid=1.
  - Same edge: shifter <= buffer, parity <= ^buffer ^ PARITY_ODD, buf_valid <= 0.
  - A tx_start on that same edge is ignored, because tx_ready was 0.
- FSM: IDLE, START, DATA, PARITY, STOP. All transitions occur only on clk edges with baud_tx=1; with baud_tx=0, state and tx hold.
  - IDLE, tx=1: if buf_valid, load and go to START with tx<=0; else stay.
  - START: go to DATA with tx<=shifter[0]; count<=0.
  - DATA: if count==DATA_BITS-1, go to PARITY with tx<=parity. Else tx<=shifter[count+1] and count<=count+1.
  - PARITY: go to STOP with tx<=1.
  - STOP: tx_done<=1 for this clk only. If buf_valid, load and go to START with tx<=0 (no idle bit). Else go to IDLE with tx<=1.
- Latency:
  - First baud_tx after acceptance (FSM in IDLE) drives the start bit.
  - Frame length is DATA_BITS+3 bit periods.
  - tx_done fires on the (DATA_BITS+4)th baud_tx after acceptance, i.e. the 12th for 8 bits.
- busy = (state != IDLE) || buf_valid.
- tx is driven from a flop only; no combinational path from any input to tx.
- Receiver compatibility: the receiver samples the start bit one tick after the tick that drives it. It then samples each subsequent bit one tick after that bit is launched. The tick-aligned launch above is therefore the required alignment.

Test Plan:
- Reset, then 20 baud ticks with no writes -> tx=1 throughout; tx_ready=1; busy=0; tx_done never pulses.
- Write 0xA5 in IDLE -> tx sequence per tick: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. tx_done on 12th tick; busy drops the following cycle.
- Write 0x07 -> data 1,1,1,0,0,0,0,0, parity 1 (even). Rebuild with PARITY_ODD=1 -> parity 0.
- Write 0x3C, then 0xC3 while frame 1 is in DATA (accepted, tx_ready goes 0), then 0xFF while tx_ready=0:
  - 0xFF is ignored.
  - Frame 2's start bit directly follows frame 1's stop bit.
  - Exactly two tx_done pulses.
- Assert rst during the DATA state of 0x55 -> tx=1 asynchronously (before the next clk edge); tx_ready=1; busy=0. A new write of 0x81 afterwards transmits correctly.
- Loopback tx into the UART receiver sharing the same baud tick, bytes 0x00, 0xFF, 0x5A, 0x96 -> receiver data_out equals each byte; p_err=0 for every frame.
